// File: rtl/avg_bcd_conv_pkg.sv
// Shared constants for the moving-average to BCD converter: FSM encoding,
// double-dabble threshold and active-low gfedcba seven-segment codes.
package avg_bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // ceil(width * 0.302) + 1 nibbles, in integer arithmetic
  function automatic int scratch_nibbles(input int width);
    return (width * 302 + 999) / 1000 + 1;
  endfunction

endpackage

// File: rtl/avg_bcd_conv_seg7_dec.sv
// Seven-segment decoder: one BCD digit to active-low gfedcba segments;
// codes above 9 are blanked.
module seg7_dec
  import avg_bcd_conv_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/avg_bcd_conv.sv
// Signed moving-average to sign + three BCD digits via serial double dabble.
// Optional seven-segment outputs when AVG_BCD_SEG_DECODE_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for avg_valid; capture sign and magnitude
//   SHIFT | one double-dabble step per cycle, WIDTH cycles
//   DONE  | one-cycle done pulse, digits freshly loaded
module avg_bcd_conv
  import avg_bcd_conv_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] avg_in,
  input  logic                    avg_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    drop,
  output logic                    sign,
  output logic [3:0]              bcd_h,
  output logic [3:0]              bcd_t,
  output logic [3:0]              bcd_o
`ifdef AVG_BCD_SEG_DECODE_EN
  ,
  output logic [6:0]              hex_sgn,
  output logic [6:0]              hex_h,
  output logic [6:0]              hex_t,
  output logic [6:0]              hex_o
`endif
);

  localparam int NIB   = scratch_nibbles(WIDTH);
  localparam int SCR_W = 4 * NIB;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   raw, mag_in, mag, mag_nxt;
  logic [SCR_W-1:0]   scr, scr_adj, scr_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               sign_cap;
  logic               last_step;

  assign raw       = $unsigned(avg_in);
  // two's-complement negate as unsigned so -2^(WIDTH-1) maps to 2^(WIDTH-1)
  assign mag_in    = raw[WIDTH-1] ? (~raw + WIDTH'(1)) : raw;
  assign last_step = (cnt == LAST_STEP);

  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < NIB; i++) begin
      if (scr[4*i +: 4] >= ADD3_THRESH)
        scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
    {scr_nxt, mag_nxt} = {scr_adj, mag} << 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (avg_valid) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop     <= 1'b0;
      sign     <= 1'b0;
      bcd_h    <= 4'd0;
      bcd_t    <= 4'd0;
      bcd_o    <= 4'd0;
      sign_cap <= 1'b0;
      mag      <= '0;
      scr      <= '0;
      cnt      <= '0;
    end else begin
      drop <= avg_valid && busy;
      case (state)
        IDLE: begin
          if (avg_valid) begin
            sign_cap <= raw[WIDTH-1];
            mag      <= mag_in;
            scr      <= '0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          scr <= scr_nxt;
          mag <= mag_nxt;
          cnt <= cnt + CNT_W'(1);
          // final step: publish the result as DONE is entered
          if (last_step) begin
            sign  <= sign_cap;
            bcd_h <= scr_nxt[11:8];
            bcd_t <= scr_nxt[7:4];
            bcd_o <= scr_nxt[3:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AVG_BCD_SEG_DECODE_EN
  logic [6:0] sgn_blank;

  seg7_dec u_dec_h (.digit(bcd_h), .seg(hex_h));
  seg7_dec u_dec_t (.digit(bcd_t), .seg(hex_t));
  seg7_dec u_dec_o (.digit(bcd_o), .seg(hex_o));
  // sign position: decoder supplies the blank pattern, minus overrides it
  seg7_dec u_dec_s (.digit(4'hF), .seg(sgn_blank));

  assign hex_sgn = sign ? SEG_MINUS : sgn_blank;
`endif

endmodule

// File: tb/tb_avg_bcd_conv.sv
// Directed self-checking bench for avg_bcd_conv (WIDTH=8); hex outputs are
// checked too when AVG_BCD_SEG_DECODE_EN is defined.
module tb_avg_bcd_conv;

  logic              clk;
  logic              rst;
  logic signed [7:0] avg_in;
  logic              avg_valid;
  logic              busy, done, drop, sign;
  logic [3:0]        bcd_h, bcd_t, bcd_o;
`ifdef AVG_BCD_SEG_DECODE_EN
  logic [6:0]        hex_sgn, hex_h, hex_t, hex_o;
`endif

  int checks = 0;
  int errors = 0;
  int drops  = 0;

  avg_bcd_conv #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .avg_in    (avg_in),
    .avg_valid (avg_valid),
    .busy      (busy),
    .done      (done),
    .drop      (drop),
    .sign      (sign),
    .bcd_h     (bcd_h),
    .bcd_t     (bcd_t),
    .bcd_o     (bcd_o)
`ifdef AVG_BCD_SEG_DECODE_EN
    ,
    .hex_sgn   (hex_sgn),
    .hex_h     (hex_h),
    .hex_t     (hex_t),
    .hex_o     (hex_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the directed sequence");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic es, input logic [3:0] eh,
                         input logic [3:0] et, input logic [3:0] eo);
    chk({tag, " sign"}, 16'(sign), 16'(es));
    chk({tag, " bcd_h"}, 16'(bcd_h), 16'(eh));
    chk({tag, " bcd_t"}, 16'(bcd_t), 16'(et));
    chk({tag, " bcd_o"}, 16'(bcd_o), 16'(eo));
  endtask

  // valid presented in cycle 0; SHIFT in cycles 1..8; DONE in cycle 9
  task automatic run_conv(input string tag, input logic signed [7:0] val, input logic es,
                          input logic [3:0] eh, input logic [3:0] et, input logic [3:0] eo);
    @(negedge clk);
    avg_in    = val;
    avg_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      avg_valid = 1'b0;
      chk($sformatf("%s busy c%0d", tag, i), 16'(busy), 16'd1);
      chk($sformatf("%s done c%0d", tag, i), 16'(done), 16'(i == 9));
      chk($sformatf("%s drop c%0d", tag, i), 16'(drop), 16'd0);
    end
    chk_out({tag, " result"}, es, eh, et, eo);
    @(negedge clk);
    chk({tag, " idle busy"}, 16'(busy), 16'd0);
    chk({tag, " idle done"}, 16'(done), 16'd0);
    chk_out({tag, " hold"}, es, eh, et, eo);
  endtask

  initial begin
    rst       = 1'b0;
    avg_in    = '0;
    avg_valid = 1'b0;
    #2;
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    chk("reset drop", 16'(drop), 16'd0);
    chk_out("reset", 1'b0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_conv("p2", 8'sd2, 1'b0, 4'd0, 4'd0, 4'd2);
`ifdef AVG_BCD_SEG_DECODE_EN
    chk("p2 hex_o", 16'(hex_o), 16'(7'b0100100));
    chk("p2 hex_sgn", 16'(hex_sgn), 16'(7'b1111111));
`endif
    run_conv("m1", -8'sd1, 1'b1, 4'd0, 4'd0, 4'd1);
`ifdef AVG_BCD_SEG_DECODE_EN
    chk("m1 hex_sgn", 16'(hex_sgn), 16'(7'b0111111));
    chk("m1 hex_o", 16'(hex_o), 16'(7'b1111001));
`endif
    run_conv("m128", -8'sd128, 1'b1, 4'd1, 4'd2, 4'd8);
    run_conv("p127", 8'sd127, 1'b0, 4'd1, 4'd2, 4'd7);
    run_conv("m99", -8'sd99, 1'b1, 4'd0, 4'd9, 4'd9);
    run_conv("zero", 8'sd0, 1'b0, 4'd0, 4'd0, 4'd0);

    // second request three cycles into a conversion is dropped, not queued
    @(negedge clk);
    avg_in    = 8'sd5;
    avg_valid = 1'b1;
    drops     = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (drop) drops++;
      chk($sformatf("drp drop c%0d", i), 16'(drop), 16'(i == 4));
      chk($sformatf("drp done c%0d", i), 16'(done), 16'(i == 9));
      if (i == 3) begin
        avg_in    = 8'sd9;
        avg_valid = 1'b1;
      end else begin
        avg_valid = 1'b0;
      end
    end
    chk("drp drop count", 16'(drops), 16'd1);
    chk("drp busy after", 16'(busy), 16'd0);
    chk_out("drp result", 1'b0, 4'd0, 4'd0, 4'd5);

    // reset in SHIFT cycle 4 of a conversion of 99
    @(negedge clk);
    avg_in    = 8'sd99;
    avg_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      avg_valid = 1'b0;
    end
    @(negedge clk);
    chk("rst pre busy", 16'(busy), 16'd1);
    rst = 1'b0;
    #1;
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    chk("rst drop", 16'(drop), 16'd0);
    chk_out("rst out", 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("rst after done c%0d", i), 16'(done), 16'd0);
      chk($sformatf("rst after busy c%0d", i), 16'(busy), 16'd0);
    end
    chk_out("rst after", 1'b0, 4'd0, 4'd0, 4'd0);

    // valid held high from the very first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    avg_in    = 8'sd42;
    avg_valid = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      chk($sformatf("cont busy c%0d", c), 16'(busy), 16'((c % 10) != 0));
      chk($sformatf("cont done c%0d", c), 16'(done), 16'((c % 10) == 9));
      chk($sformatf("cont drop c%0d", c), 16'(drop), 16'((c % 10) != 1));
      if ((c % 10) == 9)
        chk_out($sformatf("cont result c%0d", c), 1'b0, 4'd0, 4'd4, 4'd2);
    end
    avg_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("cont final busy", 16'(busy), 16'd0);
    chk_out("cont final", 1'b0, 4'd0, 4'd4, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
